// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one Uart8 transmitter
// between NUM_REQ byte producers and sequences each byte through start/busy/done.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4096,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [NUM_REQ-1:0]   reqLast,
    input  logic [8*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txIn,
    input  logic                 txBusy,
    input  logic                 txDone,
    output logic                 startErr
);
    // state     | meaning
    // IDLE      | arbitrate among valid requesters (or only the lock owner)
    // START     | txStart held until txBusy, bounded by START_TIMEOUT
    // WAIT_DONE | byte on the wire, waiting for txDone
    // GAP       | idle spacing of GAP_CYCLES before the next arbitration
    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    localparam int MAX_CNT = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int PW      = $clog2(NUM_REQ);
    localparam logic [CW-1:0] START_LOAD = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);
    localparam bit            HAS_GAP    = (GAP_CYCLES > 0);

    state_t               state_q, state_d;
    logic [7:0]           tx_in_q, tx_in_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 lock_q, lock_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [7:0]           req_byte [NUM_REQ];
    logic [NUM_REQ-1:0]   owner_mask, cand, win_mask;
    logic [PW-1:0]        win, idx, ptr_next;
    logic                 found;
    int                   sum;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_byte[g] = reqData[8*g +: 8];
    end

    // Search starts at the pointer and wraps; only the owner competes while locked.
    always_comb begin
        owner_mask         = '0;
        owner_mask[owner_q] = 1'b1;
        cand  = lock_q ? (reqValid & owner_mask) : reqValid;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = PW'(sum);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_mask      = '0;
        win_mask[win] = 1'b1;
    end

    assign ptr_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        tx_in_d = tx_in_q;
        last_d  = last_q;
        grant_d = grant_q;
        ready_d = '0;
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    tx_in_d = req_byte[win];
                    last_d  = reqLast[win];
                    grant_d = win_mask;
                    ready_d = win_mask;
                    owner_d = win;
                    cnt_d   = START_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (txDone) begin
                    if (last_q) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end else begin
                        lock_d = 1'b1;
                    end
                    if (HAS_GAP) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_in_q <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            ready_q <= '0;
            lock_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_in_q <= tx_in_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign reqReady = ready_q;
    assign grant    = grant_q;
    assign txIn     = tx_in_q;
    assign startErr = err_q;
    assign txEn     = (state_q != IDLE);
    assign txStart  = (state_q == START);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural Uart8 stand-in plus per-requester
// byte queues; expected serial bytes are queued and checked on txDone.
module tb_uart_tx_arbiter;
    localparam int NREQ     = 4;
    localparam int TMO      = 64;
    localparam int GAP      = 100;
    localparam int LAT      = 3;
    localparam int BYTE_CYC = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   reqValid, reqLast, reqReady, grant;
    logic [8*NREQ-1:0] reqData;
    logic              txEn, txStart, startErr;
    logic [7:0]        txIn;

    logic              m_busy, m_done, m_kill = 1'b0;
    logic [7:0]        m_byte;
    int                m_wait, m_cnt;

    logic [NREQ-1:0]   g_valid = '0, g_last = '0, g_ready, g_grant;
    logic [8*NREQ-1:0] g_data = '0;
    logic              g_busy = 1'b0, g_done = 1'b0;
    logic              g_txEn, g_txStart, g_startErr;
    logic [7:0]        g_txIn;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [7:0]        exp_q[$];

    logic [8:0]        rmem [NREQ][8];
    int                rhead [NREQ] = '{default: 0};
    int                rtail [NREQ] = '{default: 0};

    uart_tx_arbiter #(.NUM_REQ(NREQ), .START_TIMEOUT(TMO), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqLast(reqLast),
        .reqData(reqData), .reqReady(reqReady), .grant(grant), .txEn(txEn),
        .txStart(txStart), .txIn(txIn), .txBusy(m_busy), .txDone(m_done),
        .startErr(startErr));

    uart_tx_arbiter #(.NUM_REQ(NREQ), .START_TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut_gap (
        .clk(clk), .reset(reset), .reqValid(g_valid), .reqLast(g_last),
        .reqData(g_data), .reqReady(g_ready), .grant(g_grant), .txEn(g_txEn),
        .txStart(g_txStart), .txIn(g_txIn), .txBusy(g_busy), .txDone(g_done),
        .startErr(g_startErr));

    // Uart8 stand-in: busy LAT cycles after txStart is seen, done after BYTE_CYC.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_wait <= 0;
            m_cnt  <= 0;
            m_byte <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_cnt <= m_cnt - 1;
            end else if (txEn && txStart && !m_kill) begin
                if (m_wait == LAT - 1) begin
                    m_busy <= 1'b1;
                    m_byte <= txIn;
                    m_cnt  <= BYTE_CYC;
                    m_wait <= 0;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else begin
                m_wait <= 0;
            end
        end
    end

    always_comb begin
        reqValid = '0;
        reqLast  = '0;
        reqData  = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqValid[i]       = (rhead[i] != rtail[i]);
            reqLast[i]        = rmem[i][rhead[i] % 8][8];
            reqData[8*i +: 8] = rmem[i][rhead[i] % 8][7:0];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (reqReady[i] && rhead[i] != rtail[i]) rhead[i] = rhead[i] + 1;
    end

    task automatic push_req(input int i, input logic [7:0] d, input logic l);
        rmem[i][rtail[i] % 8] = {l, d};
        rtail[i] = rtail[i] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int got = 0;
        int budget = 0;
        logic [7:0] e;
        while (got < n && budget < 300 * n) begin
            @(negedge clk);
            budget++;
            if (m_done) begin
                got++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL byte_order: got %h, required no byte", m_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (m_byte !== e) begin
                        n_bad++;
                        $display("FAIL byte_order: got %h, required %h", m_byte, e);
                    end
                end
            end
        end
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got %0d bytes, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({reqReady, grant, txEn, txStart, txIn, startErr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b gnt=%b en=%b st=%b in=%h err=%b, required all 0",
                     reqReady, grant, txEn, txStart, txIn, startErr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (txEn !== 1'b0 || grant !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: en=%b gnt=%b, required 0/0000", txEn, grant);
        end
    endtask

    task automatic test_single();
        int cnt;
        push_req(0, 8'h7A, 1'b1);
        exp_q.push_back(8'h7A);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (reqReady !== 4'b0001 || txEn !== 1'b1 || txStart !== 1'b1 || grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL grant_latency: rdy=%b en=%b st=%b gnt=%b, required 0001/1/1/0001",
                     reqReady, txEn, txStart, grant);
        end
        cnt = 1;
        @(negedge clk);
        n_cmp++;
        if (reqReady !== 4'b0000) begin
            n_bad++;
            $display("FAIL ready_single_pulse: rdy=%b, required 0000", reqReady);
        end
        while (txStart === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != LAT + 1 || m_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_until_busy: high %0d cycles busy=%b, required %0d cycles busy=1",
                     cnt, m_busy, LAT + 1);
        end
        wait_bytes(1);
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0 || txEn !== 1'b0) begin
            n_bad++;
            $display("FAIL grant_release: gnt=%b en=%b, required 0000/0", grant, txEn);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_req(0, 8'h11, 1'b1);
            push_req(1, 8'h22, 1'b1);
            push_req(2, 8'h33, 1'b1);
            exp_q.push_back(8'h11);
            exp_q.push_back(8'h22);
            exp_q.push_back(8'h33);
            wait_bytes(3);
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
        int cnt = 0;
        logic stall_ok = 1'b1;
        push_req(1, 8'hB1, 1'b0);
        exp_q.push_back(8'hB1);
        while (reqReady[1] !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        push_req(0, 8'h44, 1'b1);
        wait_bytes(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant !== 4'b0010 || txEn !== 1'b0 || reqReady !== 4'b0) stall_ok = 1'b0;
        end
        n_cmp++;
        if (!stall_ok) begin
            n_bad++;
            $display("FAIL lock_stall: gnt=%b en=%b rdy=%b, required 0010/0/0000", grant, txEn, reqReady);
        end
        push_req(1, 8'h55, 1'b1);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h44);
        cnt = 0;
        while (reqReady === 4'b0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (reqReady !== 4'b0010 || grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL lock_owner: rdy=%b gnt=%b, required 0010/0010", reqReady, grant);
        end
        wait_bytes(2);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cnt = 0;
        push_req(1, 8'h60, 1'b0);
        exp_q.push_back(8'h60);
        wait_bytes(1);
        @(negedge clk);
        m_kill = 1'b1;
        push_req(1, 8'h66, 1'b0);
        push_req(2, 8'h77, 1'b1);
        while (txStart !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (startErr !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        m_kill = 1'b0;
        n_cmp++;
        if (cnt != TMO) begin
            n_bad++;
            $display("FAIL timeout_latency: %0d cycles, required %0d", cnt, TMO);
        end
        n_cmp++;
        if (txStart !== 1'b0 || grant !== 4'b0) begin
            n_bad++;
            $display("FAIL timeout_release: st=%b gnt=%b, required 0/0000", txStart, grant);
        end
        @(negedge clk);
        n_cmp++;
        if (startErr !== 1'b0 || reqReady !== 4'b0100) begin
            n_bad++;
            $display("FAIL timeout_next: err=%b rdy=%b, required 0/0100", startErr, reqReady);
        end
        exp_q.push_back(8'h77);
        wait_bytes(1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        logic quiet = 1'b1;
        push_req(3, 8'h99, 1'b1);
        while (!(m_busy === 1'b1 && txStart === 1'b0) && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (txEn !== 1'b0 || txStart !== 1'b0 || grant !== 4'b0 || reqReady !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_mid: en=%b st=%b gnt=%b rdy=%b, required 0/0/0000/0000",
                     txEn, txStart, grant, reqReady);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (reqReady !== 4'b0 || startErr !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: rdy=%b err=%b, required 0000/0", reqReady, startErr);
        end
        push_req(3, 8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        wait_bytes(1);
    endtask

    task automatic test_gap();
        int cnt = 0;
        g_valid = 4'b0001;
        g_last  = 4'b0001;
        g_data  = 32'h0000_00C1;
        while (g_ready[0] !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (g_txStart !== 1'b1 || g_txIn !== 8'hC1) begin
            n_bad++;
            $display("FAIL gap_first: st=%b in=%h, required 1/c1", g_txStart, g_txIn);
        end
        g_data = 32'h0000_00C2;
        @(negedge clk);
        g_busy = 1'b1;
        cnt = 0;
        while (g_txStart === 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(negedge clk);
        g_busy = 1'b0;
        g_done = 1'b1;
        @(negedge clk);
        g_done = 1'b0;
        cnt = 1;
        n_cmp++;
        if (g_txEn !== 1'b1 || g_txStart !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_hold: en=%b st=%b, required 1/0", g_txEn, g_txStart);
        end
        while (g_txStart !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt != GAP + 2 || g_ready !== 4'b0001 || g_txIn !== 8'hC2) begin
            n_bad++;
            $display("FAIL gap_spacing: start at %0d rdy=%b in=%h, required %0d/0001/c2",
                     cnt, g_ready, g_txIn, GAP + 2);
        end
        g_valid = 4'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 8; j++) rmem[i][j] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
